// File: rtl/pc_fetch_ram.sv
// PC-driven fetch/store engine over a single-port synchronous RAM.
// A fetch takes READ (RAM access) then LATCH (capture word, advance PC); stores go through WRITE.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting; accepts load_pc, wr_en, step edge or run
// S_READ  | RAM addressed with pc, read data registered at end of cycle
// S_LATCH | RAM word captured into q, q_valid pulsed, pc advanced/loaded
// S_WRITE | wr_data stored at mem[pc] and mirrored onto q
module pc_fetch_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_pc,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              step,
  input  logic              run,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy,
  output logic              wrap
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_LATCH = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // One extra bit so DEPTH == 2**ADDR_W is representable in the legality compare.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;

  logic              step_q;
  logic              step_rise;
  logic              ld_ok;
  logic              pc_last;
  logic [ADDR_W-1:0] pc_inc;

  logic pc_ld;
  logic pc_adv;
  logic wrap_clr;
  logic q_cap;
  logic q_wr;
  logic mem_we;
  logic rd_en;

  assign step_rise = step & ~step_q;
  assign ld_ok     = ({1'b0, ld_addr} < DEPTH_X);
  assign pc_last   = (pc == LAST_PC);
  assign pc_inc    = pc_last ? '0 : pc + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (load_pc) begin
          state_nxt = S_IDLE;
        end else if (wr_en) begin
          state_nxt = S_WRITE;
        end else if (step_rise || run) begin
          state_nxt = S_READ;
        end
      end
      S_READ:  state_nxt = S_LATCH;
      S_LATCH: begin
        if (load_pc && ld_ok) begin
          state_nxt = S_IDLE;
        end else if (run) begin
          state_nxt = S_READ;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pc_ld    = 1'b0;
    pc_adv   = 1'b0;
    wrap_clr = 1'b0;
    q_cap    = 1'b0;
    q_wr     = 1'b0;
    mem_we   = 1'b0;
    rd_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_pc && ld_ok) begin
          pc_ld    = 1'b1;
          wrap_clr = 1'b1;
        end
      end
      S_READ: rd_en = 1'b1;
      S_LATCH: begin
        q_cap = 1'b1;
        if (load_pc && ld_ok) begin
          pc_ld = 1'b1;
        end else begin
          pc_adv = 1'b1;
        end
      end
      S_WRITE: begin
        mem_we = 1'b1;
        q_wr   = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Write is suppressed under reset so an aborted WRITE leaves the old word intact.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[pc] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[pc];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      wrap    <= 1'b0;
      step_q  <= 1'b1;
    end else begin
      step_q  <= step;
      q_valid <= q_cap;
      if (pc_ld) begin
        pc <= ld_addr;
      end else if (pc_adv) begin
        pc <= pc_inc;
      end
      if (wrap_clr) begin
        wrap <= 1'b0;
      end else if (pc_adv && pc_last) begin
        wrap <= 1'b1;
      end
      if (q_cap) begin
        q <= rd_data;
      end else if (q_wr) begin
        q <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ram.sv
// Scoreboarded bench for pc_fetch_ram: the driver predicts each fetch (word, pc, cycle)
// from an array model of memory and PC; a negedge monitor checks every q_valid pulse.
module tb_pc_fetch_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       load_pc;
  logic [7:0] ld_addr;
  logic       step;
  logic       run;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] pc;
  logic [7:0] q;
  logic       q_valid;
  logic       busy;
  logic       wrap;

  logic       d2_load_pc;
  logic [7:0] d2_ld_addr;
  logic       d2_step;
  logic       d2_run;
  logic       d2_wr_en;
  logic [7:0] d2_wr_data;
  logic [7:0] d2_pc;
  logic [7:0] d2_q;
  logic       d2_q_valid;
  logic       d2_busy;
  logic       d2_wrap;

  pc_fetch_ram dut (
    .clk(clk), .reset(reset), .load_pc(load_pc), .ld_addr(ld_addr), .step(step),
    .run(run), .wr_en(wr_en), .wr_data(wr_data), .pc(pc), .q(q), .q_valid(q_valid),
    .busy(busy), .wrap(wrap)
  );

  pc_fetch_ram #(.ADDR_W(8), .DATA_W(8), .DEPTH(200)) dut2 (
    .clk(clk), .reset(reset), .load_pc(d2_load_pc), .ld_addr(d2_ld_addr), .step(d2_step),
    .run(d2_run), .wr_en(d2_wr_en), .wr_data(d2_wr_data), .pc(d2_pc), .q(d2_q),
    .q_valid(d2_q_valid), .busy(d2_busy), .wrap(d2_wrap)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] pc;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] mem_m [256];
  logic [7:0] pc_m;
  logic       wrap_m;
  int         cyc   = 0;
  int         tests = 0;
  int         fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (q_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_q_valid: q=%0h pc=%0h at cycle %0d, expected no fetch", q, pc, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("fetch_q", q, mon_e.data);
        chk("fetch_pc", pc, mon_e.pc);
        chk("fetch_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Predict one fetch at the current model pc and advance the model pc.
  task automatic push_fetch(input int c);
    exp_t e;
    e.data = mem_m[pc_m];
    if (pc_m == 8'd255) begin
      pc_m   = 8'd0;
      wrap_m = 1'b1;
    end else begin
      pc_m = pc_m + 8'd1;
    end
    e.pc  = pc_m;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    pc_m   = 8'd0;
    wrap_m = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] a);
    load_pc = 1'b1;
    ld_addr = a;
    tick();
    load_pc = 1'b0;
    pc_m    = a;
    wrap_m  = 1'b0;
    chk("load_pc", pc, pc_m);
    chk("load_wrap", wrap, wrap_m);
  endtask

  task automatic do_write(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    chk("write_busy", busy, 1);
    tick();
    mem_m[pc_m] = d;
    chk("write_q", q, d);
    chk("write_pc", pc, pc_m);
    chk("write_no_qv", q_valid, 0);
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    push_fetch(cyc + 2);
    step = 1'b0;
    tick();
    tick();
    chk("step_qv", q_valid, 1);
    chk("step_q", q, mem_m[pc_m == 8'd0 ? 8'd255 : pc_m - 8'd1]);
    chk("step_pc", pc, pc_m);
    chk("step_wrap", wrap, wrap_m);
  endtask

  task automatic do_run(input int n);
    int c0;
    run = 1'b1;
    tick();
    c0 = cyc;
    for (int i = 0; i < n; i++) push_fetch(c0 + 2 + 2 * i);
    for (int i = 0; i < 2 * n - 1; i++) tick();
    run = 1'b0;
    tick();
    chk("run_pc", pc, pc_m);
    chk("run_wrap", wrap, wrap_m);
    chk("run_busy_end", busy, 0);
  endtask

  initial begin
    int c0;
    exp_t e;
    reset = 1'b1; load_pc = 1'b0; ld_addr = '0; step = 1'b0; run = 1'b0;
    wr_en = 1'b0; wr_data = '0;
    d2_load_pc = 1'b0; d2_ld_addr = '0; d2_step = 1'b0; d2_run = 1'b0;
    d2_wr_en = 1'b0; d2_wr_data = '0;
    pc_m = '0; wrap_m = 1'b0;

    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_q", q, 0);
    chk("rst_qv", q_valid, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_busy", busy, 0);

    // write then single step at address 0
    do_write(8'hA5);
    do_step();
    chk("first_fetch_pc", pc, 8'h01);

    // run across the top of memory
    do_load(8'hFE); do_write(8'h11);
    do_load(8'hFF); do_write(8'h22);
    do_load(8'hFE);
    do_run(3);
    chk("run_wrap_set", wrap, 1);
    chk("run_pc_after_wrap", pc, 8'h01);

    // load_pc beats wr_en in the same IDLE cycle
    do_load(8'h10); do_write(8'h3C);
    do_load(8'h20);
    load_pc = 1'b1; ld_addr = 8'h10; wr_en = 1'b1; wr_data = 8'h77;
    tick();
    load_pc = 1'b0; wr_en = 1'b0;
    pc_m = 8'h10; wrap_m = 1'b0;
    chk("ldwr_busy", busy, 0);
    chk("ldwr_pc", pc, 8'h10);
    tick();
    chk("ldwr_busy_after", busy, 0);
    do_step();

    // step held high gives exactly one fetch
    do_write(8'h5E);
    step = 1'b1;
    tick();
    push_fetch(cyc + 2);
    for (int i = 0; i < 9; i++) tick();
    step = 1'b0;
    tick();
    chk("held_pc", pc, 8'h12);
    chk("held_busy", busy, 0);

    // reset while in READ
    do_load(8'hFE);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("read_busy", busy, 1);
    reset = 1'b1;
    tick();
    chk("rstread_pc", pc, 0);
    chk("rstread_q", q, 0);
    chk("rstread_qv", q_valid, 0);
    chk("rstread_wrap", wrap, 0);
    chk("rstread_busy", busy, 0);
    reset = 1'b0;
    pc_m = 8'd0; wrap_m = 1'b0;
    tick();
    tick();
    chk("rstread_no_qv", q_valid, 0);
    do_load(8'hFE);
    do_run(2);

    // fill all of memory with random words
    for (int a = 0; a < 256; a++) begin
      do_load(8'(a));
      do_write(8'($urandom));
    end

    // legal load_pc in LATCH overrides increment and ends the run
    run = 1'b1;
    tick();
    c0 = cyc;
    e.data = mem_m[pc_m]; e.pc = 8'h40; e.cyc = c0 + 2;
    exp_q.push_back(e);
    tick();
    load_pc = 1'b1; ld_addr = 8'h40;
    tick();
    load_pc = 1'b0; run = 1'b0;
    pc_m = 8'h40;
    chk("latch_ld_pc", pc, 8'h40);
    chk("latch_ld_busy", busy, 0);
    chk("latch_ld_wrap", wrap, wrap_m);
    tick();

    // random mix of operations
    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 3))
        0: do_load(8'($urandom));
        1: do_write(8'($urandom));
        2: do_step();
        default: do_run(int'($urandom_range(1, 4)));
      endcase
    end

    // DEPTH=200 build: wrap at 199 and out-of-range loads ignored
    d2_load_pc = 1'b1; d2_ld_addr = 8'd199;
    tick();
    d2_load_pc = 1'b0;
    chk("d2_load199", d2_pc, 8'd199);
    d2_wr_en = 1'b1; d2_wr_data = 8'h5A;
    tick();
    d2_wr_en = 1'b0;
    tick();
    d2_step = 1'b1;
    tick();
    d2_step = 1'b0;
    tick();
    tick();
    chk("d2_qv", d2_q_valid, 1);
    chk("d2_q", d2_q, 8'h5A);
    chk("d2_pc_wrapped", d2_pc, 8'd0);
    chk("d2_wrap", d2_wrap, 1);
    d2_load_pc = 1'b1; d2_ld_addr = 8'hF0;
    tick();
    d2_load_pc = 1'b0;
    chk("d2_bad_ld_pc", d2_pc, 8'd0);
    chk("d2_bad_ld_wrap", d2_wrap, 1);
    chk("d2_bad_ld_busy", d2_busy, 0);
    d2_load_pc = 1'b1; d2_ld_addr = 8'd200;
    tick();
    d2_load_pc = 1'b0;
    chk("d2_ld200_pc", d2_pc, 8'd0);
    d2_load_pc = 1'b1; d2_ld_addr = 8'd5;
    tick();
    d2_load_pc = 1'b0;
    chk("d2_ld5_pc", d2_pc, 8'd5);
    chk("d2_ld5_wrap", d2_wrap, 0);

    tick();
    tick();
    chk("pending_fetches", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ram.md
PC_FETCH_RAM -- requirements
Module: pc_fetch_ram

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address/PC width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, memory word width in bits.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_W, number of words, legal range 2..2**ADDR_W.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port load_pc  input  1  load PC from ld_addr.
REQ-007 SHALL have port ld_addr  input  ADDR_W  PC load value.
REQ-008 SHALL have port step  input  1  single-fetch request, rising-edge detected internally.
REQ-009 SHALL have port run  input  1  level; continuous fetch with auto-increment while high.
REQ-010 SHALL have port wr_en  input  1  write wr_data to mem[pc].
REQ-011 SHALL have port wr_data  input  DATA_W  write data.
REQ-012 SHALL have port pc  output  ADDR_W  current program counter (registered).
REQ-013 SHALL have port q  output  DATA_W  last fetched/written word (registered).
REQ-014 SHALL have port q_valid  output  1  one-cycle pulse, new fetched word on q.
REQ-015 SHALL have port busy  output  1  high whenever FSM not IDLE.
REQ-016 SHALL have port wrap  output  1  sticky: PC auto-incremented from DEPTH-1 to 0.

Function
REQ-017 SHALL contain DEPTH x DATA_W synchronous RAM, one-cycle registered read, memory not cleared by reset.
REQ-018 SHALL implement FSM states IDLE, READ, LATCH, WRITE.
REQ-019 IDLE priority, highest first: load_pc -> pc<=ld_addr, stay IDLE; wr_en -> WRITE; step rising edge or run -> READ; else stay IDLE.
REQ-020 load_pc with ld_addr >= DEPTH SHALL be ignored (pc unchanged), still takes priority over wr_en/step/run that cycle.
REQ-021 READ: RAM address = pc; next state LATCH unconditionally; load_pc, wr_en, step ignored.
REQ-022 LATCH: q<=RAM output, q_valid<=1 (high exactly the following cycle), pc<=pc+1 or 0 if pc==DEPTH-1 (then wrap<=1).
REQ-023 LATCH: legal load_pc SHALL override increment (pc<=ld_addr, wrap unchanged, q still updated) and force next state IDLE; else next state READ if run high, IDLE otherwise.
REQ-024 WRITE: mem[pc]<=wr_data, q<=wr_data, pc unchanged, q_valid stays 0, next state IDLE.
REQ-025 Latency: step edge sampled at edge E0 -> q/q_valid updated at E2; run sustains one word per 2 cycles.
REQ-026 step edge detect SHALL use a registered copy of step; a step held high yields exactly one fetch.
REQ-027 wrap SHALL clear only on reset or accepted load_pc in IDLE.
REQ-028 busy SHALL be combinational (state != IDLE); all other outputs registered.
REQ-029 PC arithmetic SHALL be ADDR_W bits, modulo DEPTH, no overflow beyond DEPTH-1.

Reset
REQ-030 reset high at a clock edge SHALL force state IDLE, pc=0, q=0, q_valid=0, wrap=0, step edge register=1, from any state including mid-READ/LATCH/WRITE.
REQ-031 reset aborting WRITE SHALL leave addressed RAM word either old or new value, never corrupted; reset aborting READ/LATCH SHALL produce no q_valid.

Verification (ADDR_W=8, DATA_W=8 unless noted)
REQ-032 reset; wr_en, wr_data=0xA5 -> mem[0]=0xA5, q=0xA5, pc=0, no q_valid; step pulse -> q=0xA5, one q_valid pulse two edges after sampling, pc=1.
REQ-033 load 0xFE, write 0x11; load 0xFF, write 0x22; load 0xFE; run 6 cycles -> q 0x11, 0x22, mem[0] on q_valid every 2 cycles; pc FE->FF->00->01; wrap set at FF->00.
REQ-034 load_pc=1 ld_addr=0x10 and wr_en=1 same IDLE cycle -> pc=0x10, memory unchanged, busy stays 0.
REQ-035 step held high 10 cycles -> exactly one q_valid, pc advances by 1.
REQ-036 reset asserted while state READ -> next cycle all outputs at reset values, no q_valid; prior written words read back unchanged.
REQ-037 DEPTH=200 build: pc=199 fetched -> pc=0, wrap=1; load_pc ld_addr=0xF0 -> pc unchanged.
